// File: rtl/zephyr_core_p.sv
// zephyr_core_p: parametrised multi-cycle core with a req/ack memory port,
// arithmetic, branches, HALT and single-step debug.
module zephyr_core_p #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned RSEL_W = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK,
  input  logic              STEP_MODE,
  input  logic              STEP,
  output logic              HALTED,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic [2:0]        STATE_OUT
);

  localparam int unsigned IW   = 3 + RSEL_W + ADDR_W;
  localparam int unsigned NREG = 1 << RSEL_W;

  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_STR  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_JZ   = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXECUTE  = 3'd2,
    S_MEMREAD  = 3'd3,
    S_MEMWRITE = 3'd4,
    S_REGWRITE = 3'd5,
    S_HALT     = 3'd6
  } state_e;

  // The instruction must fit in one memory word.
  if (DATA_W < IW) begin : g_bad_params
    $error("zephyr_core_p: DATA_W must be >= 3+RSEL_W+ADDR_W");
  end

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [IW-1:0]       ir_q, ir_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                halted_q, halted_d;

  logic [2:0]          op;
  logic [RSEL_W-1:0]   rs;
  logic [ADDR_W-1:0]   iaddr;
  logic                xfer;

  // Instruction fields and completed-transfer strobe.
  assign op    = ir_q[IW-1 -: 3];
  assign rs    = ir_q[IW-4 -: RSEL_W];
  assign iaddr = ir_q[ADDR_W-1:0];
  assign xfer  = mem_req_q && MEM_ACK;

  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign HALTED    = halted_q;
  assign PC_OUT    = pc_q;
  assign STATE_OUT = state_q;

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (xfer) state_d = S_DECODE;
      S_DECODE:   state_d = S_EXECUTE;
      S_EXECUTE: begin
        case (op)
          OP_LOAD, OP_ADD: state_d = S_MEMREAD;
          OP_STR:          state_d = S_MEMWRITE;
          OP_HALT:         state_d = S_HALT;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEMREAD:  if (xfer) state_d = S_REGWRITE;
      S_MEMWRITE: if (xfer) state_d = S_FETCH;
      S_REGWRITE: state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // Datapath updates and next-cycle bus outputs, derived from registered state.
  always_comb begin
    pc_d        = pc_q;
    ir_d        = ir_q;
    mdr_d       = mdr_q;
    regs_d      = regs_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_FETCH: begin
        if (xfer) begin
          ir_d = MEM_RDATA[IW-1:0];
          pc_d = pc_q + ADDR_W'(1);
        end
      end
      S_EXECUTE: begin
        if (op == OP_JMP) pc_d = iaddr;
        if (op == OP_JZ && regs_q[rs] == '0) pc_d = iaddr;
      end
      S_MEMREAD: if (xfer) mdr_d = MEM_RDATA;
      S_REGWRITE: begin
        if (op == OP_ADD) regs_d[rs] = regs_q[rs] + mdr_q;
        else              regs_d[rs] = mdr_q;
      end
      default: ;
    endcase

    case (state_d)
      S_FETCH: begin
        mem_addr_d = pc_d;
        // A pending fetch is held; a gated fetch opens on STEP or leaving step mode.
        if (state_q == S_FETCH) mem_req_d = mem_req_q || !STEP_MODE || STEP;
        else                    mem_req_d = !STEP_MODE;
      end
      S_MEMREAD: begin
        mem_req_d  = 1'b1;
        mem_addr_d = iaddr;
      end
      S_MEMWRITE: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = iaddr;
        mem_wdata_d = regs_d[rs];
      end
      default: ;
    endcase

    halted_d = (state_d == S_HALT);
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pc_q        <= '0;
      ir_q        <= '0;
      mdr_q       <= '0;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      mdr_q       <= mdr_d;
      regs_q      <= regs_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= halted_d;
    end
  end

endmodule

// File: tb/tb_zephyr_core_p.sv
// Testbench for zephyr_core_p: RAM responder with programmable wait states,
// an instruction-level reference model and directed programs.
module tb_zephyr_core_p;

  localparam int unsigned DW = 12;
  localparam int unsigned AW = 6;
  localparam int unsigned NW = 64;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic          fetch;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
  logic          mem_req, mem_we, halted;
  logic          mem_ack = 1'b0;
  logic [AW-1:0] mem_addr, pc_out;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [2:0]    state_out;

  int checks = 0;
  int failures = 0;

  int   wait_n = 0;
  bit   mon_en = 1'b0;
  logic [DW-1:0] ram [NW];
  logic [DW-1:0] wr_log [int];
  txn_t exp_a [$];
  txn_t t_cur;
  int   cyc = 0;
  int   wait_cnt = 0;
  int   exp_i = 0;
  int   fa_cyc [$];
  int   fa_addr [$];
  int   st_hist [int];
  bit   prev_pend = 1'b0;
  logic [AW-1:0] prev_addr;
  logic          prev_we;
  logic [DW-1:0] prev_wdata;

  logic [DW-1:0] m_regs [4];
  logic [DW-1:0] m_mem [NW];
  logic [AW-1:0] m_pc;
  bit            m_halted;

  int bad;
  int k;
  int seq1 [18] = '{0,1,2,3,5, 0,1,2,4, 0,1,2,3,5, 0,1,2,4};
  int fa3  [8]  = '{0,10,11,12,63,0,1,2};

  always #5 clk = ~clk;

  zephyr_core_p dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .MEM_REQ   (mem_req),
    .MEM_WE    (mem_we),
    .MEM_ADDR  (mem_addr),
    .MEM_WDATA (mem_wdata),
    .MEM_RDATA (mem_rdata),
    .MEM_ACK   (mem_ack),
    .STEP_MODE (step_mode),
    .STEP      (step),
    .HALTED    (halted),
    .PC_OUT    (pc_out),
    .STATE_OUT (state_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input int a);
    if (wr_log.exists(a)) return wr_log[a];
    return ram[a];
  endfunction

  // Instruction-level reference: expected bus transactions in order.
  task automatic model_run(input int max_instr);
    logic [AW-1:0] pc;
    logic [DW-1:0] ir;
    logic [2:0]    op;
    logic [1:0]    rs;
    logic [AW-1:0] a;
    m_mem = ram;
    pc = '0;
    m_halted = 1'b0;
    for (int r = 0; r < 4; r++) m_regs[r] = '0;
    exp_a.delete();
    for (int n = 0; n < max_instr && !m_halted; n++) begin
      exp_a.push_back(txn_t'{addr: pc, we: 1'b0, wdata: '0, fetch: 1'b1});
      ir = m_mem[pc];
      pc = AW'(pc + 1);
      op = ir[10:8];
      rs = ir[7:6];
      a  = ir[5:0];
      case (op)
        3'b001: begin
          exp_a.push_back(txn_t'{addr: a, we: 1'b0, wdata: '0, fetch: 1'b0});
          m_regs[rs] = m_mem[a];
        end
        3'b010: begin
          exp_a.push_back(txn_t'{addr: a, we: 1'b1, wdata: m_regs[rs], fetch: 1'b0});
          m_mem[a] = m_regs[rs];
        end
        3'b011: begin
          exp_a.push_back(txn_t'{addr: a, we: 1'b0, wdata: '0, fetch: 1'b0});
          m_regs[rs] = DW'(m_regs[rs] + m_mem[a]);
        end
        3'b100: pc = a;
        3'b101: if (m_regs[rs] == '0) pc = a;
        3'b111: m_halted = 1'b1;
        default: ;
      endcase
    end
    m_pc = pc;
  endtask

  // RAM responder and per-cycle compare against the reference transactions.
  always @(negedge clk) begin
    cyc++;
    st_hist[cyc] = int'(state_out);
    if (!rst_n) begin
      mem_ack   = 1'b0;
      wait_cnt  = 0;
      prev_pend = 1'b0;
      exp_i     = 0;
      wr_log.delete();
      fa_cyc.delete();
      fa_addr.delete();
    end else begin
      if (prev_pend) begin
        chk("req_held", 64'(mem_req), 64'(1));
        chk("addr_stable", 64'(mem_addr), 64'(prev_addr));
        chk("we_stable", 64'(mem_we), 64'(prev_we));
        chk("wdata_stable", 64'(mem_wdata), 64'(prev_wdata));
      end
      if (mem_req && wait_cnt >= wait_n) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = mem_req ? wait_cnt + 1 : 0;
      end
      mem_rdata = mem_rd(int'(mem_addr));
      if (mem_req && mem_ack) begin
        if (state_out == 3'd0) begin
          fa_cyc.push_back(cyc);
          fa_addr.push_back(int'(mem_addr));
        end
        if (mon_en && exp_i < exp_a.size()) begin
          t_cur = exp_a[exp_i];
          exp_i++;
          chk("txn_addr", 64'(mem_addr), 64'(t_cur.addr));
          chk("txn_we", 64'(mem_we), 64'(t_cur.we));
          chk("txn_is_fetch", 64'(state_out == 3'd0), 64'(t_cur.fetch));
          if (t_cur.we) chk("txn_wdata", 64'(mem_wdata), 64'(t_cur.wdata));
          if (t_cur.fetch) chk("pc_at_fetch", 64'(pc_out), 64'(t_cur.addr));
        end
        if (mem_we) wr_log[int'(mem_addr)] = mem_wdata;
      end
      prev_pend  = mem_req && !mem_ack;
      prev_addr  = mem_addr;
      prev_we    = mem_we;
      prev_wdata = mem_wdata;
    end
  end

  task automatic reset_assert();
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    for (int i = 0; i < int'(NW); i++) ram[i] = '0;
  endtask

  task automatic release_run();
    model_run(40);
    repeat (2) @(negedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    #1;
    chk("halt_reached", 64'(halted), 64'(1));
    chk("all_txns_seen", 64'(exp_i), 64'(exp_a.size()));
  endtask

  task automatic pulse_step();
    @(negedge clk);
    #2;
    step = 1'b1;
    @(negedge clk);
    #2;
    step = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset values and zero-wait load/store program.
    reset_assert();
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_halted", 64'(halted), 64'(0));
    chk("rst_pc", 64'(pc_out), 64'(0));
    chk("rst_state", 64'(state_out), 64'(0));
    wait_n = 0;
    step_mode = 1'b0;
    ram[0] = 12'h13F;  // LOAD R0,63
    ram[1] = 12'h23D;  // STR  R0,61
    ram[2] = 12'h17E;  // LOAD R1,62
    ram[3] = 12'h27C;  // STR  R1,60
    ram[4] = 12'h700;  // HALT
    ram[63] = 12'hFFF;
    ram[62] = 12'hFFA;
    release_run();
    chk("model_r0", 64'(m_regs[0]), 64'(12'hFFF));
    chk("model_r1", 64'(m_regs[1]), 64'(12'hFFA));
    chk("model_mem61", 64'(m_mem[61]), 64'(12'hFFF));
    wait_halt(200);
    chk("p1_mem61", 64'(mem_rd(61)), 64'(12'hFFF));
    chk("p1_mem60", 64'(mem_rd(60)), 64'(12'hFFA));
    chk("p1_fetch_count", 64'(fa_cyc.size()), 64'(5));
    if (fa_cyc.size() >= 5) begin
      chk("p1_total_cycles", 64'(fa_cyc[4] - fa_cyc[0]), 64'(18));
      bad = 0;
      for (int i = 0; i < 18; i++)
        if (st_hist[fa_cyc[0] + i] != seq1[i]) bad++;
      chk("p1_state_sequence_bad", 64'(bad), 64'(0));
    end

    // HALT holds for 50 cycles and ignores STEP.
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!halted || mem_req || state_out != 3'd6) bad++;
      #2;
      step = ~step;
    end
    step = 1'b0;
    chk("halt_hold_bad_cycles", 64'(bad), 64'(0));

    // ADD wraps modulo 2**DATA_W; upper instruction bits ignored (0xF00 = HALT).
    reset_assert();
    ram[0] = 12'h1BF;  // LOAD R2,63
    ram[1] = 12'h3BB;  // ADD  R2,59
    ram[2] = 12'h2B2;  // STR  R2,50
    ram[3] = 12'hF00;  // HALT with bit 11 set
    ram[63] = 12'hFFF;
    ram[59] = 12'h002;
    release_run();
    chk("model_add_wrap", 64'(m_regs[2]), 64'(12'h001));
    wait_halt(200);
    chk("add_wrap_mem50", 64'(mem_rd(50)), 64'(12'h001));

    // Branches: JZ taken, JZ not taken, JMP to 63, JMP 0 from 63.
    reset_assert();
    ram[0]  = 12'h5CA;  // JZ   R3,10
    ram[1]  = 12'h2E9;  // STR  R3,41
    ram[2]  = 12'h700;  // HALT
    ram[10] = 12'h1E8;  // LOAD R3,40
    ram[11] = 12'h5D4;  // JZ   R3,20
    ram[12] = 12'h43F;  // JMP  63
    ram[63] = 12'h400;  // JMP  0
    ram[40] = 12'h005;
    release_run();
    k = 0;
    foreach (exp_a[i]) begin
      if (exp_a[i].fetch) begin
        if (k < 8) chk("model_fetch_addr", 64'(exp_a[i].addr), 64'(fa3[k]));
        k++;
      end
    end
    chk("model_fetch_count", 64'(k), 64'(8));
    wait_halt(200);
    chk("br_fetch_count", 64'(fa_addr.size()), 64'(8));
    for (int i = 0; i < 8 && i < fa_addr.size(); i++)
      chk("br_fetch_addr", 64'(fa_addr[i]), 64'(fa3[i]));
    chk("br_pc_final", 64'(pc_out), 64'(3));
    chk("br_mem41", 64'(mem_rd(41)), 64'(12'h005));

    // Three wait states on every request.
    reset_assert();
    wait_n = 3;
    ram[0] = 12'h13F;  // LOAD R0,63
    ram[1] = 12'h23D;  // STR  R0,61
    ram[2] = 12'h700;  // HALT
    ram[63] = 12'hABC;
    release_run();
    wait_halt(300);
    chk("ws_fetch_count", 64'(fa_cyc.size()), 64'(3));
    if (fa_cyc.size() >= 3) begin
      chk("ws_load_cycles", 64'(fa_cyc[1] - fa_cyc[0]), 64'(11));
      chk("ws_store_cycles", 64'(fa_cyc[2] - fa_cyc[1]), 64'(10));
    end
    chk("ws_mem61", 64'(mem_rd(61)), 64'(12'hABC));

    // Single-step: idle while STEP low, one instruction per pulse.
    reset_assert();
    wait_n = 0;
    step_mode = 1'b1;
    ram[0] = 12'h13F;
    ram[1] = 12'h23D;
    ram[2] = 12'h700;
    ram[63] = 12'h5A5;
    release_run();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req || state_out != 3'd0) bad++;
    end
    chk("step_idle_bad_cycles", 64'(bad), 64'(0));
    pulse_step();
    repeat (15) @(negedge clk);
    #1;
    chk("step1_fetches", 64'(fa_addr.size()), 64'(1));
    chk("step1_state", 64'(state_out), 64'(0));
    chk("step1_req", 64'(mem_req), 64'(0));
    chk("step1_pc", 64'(pc_out), 64'(1));
    pulse_step();
    repeat (15) @(negedge clk);
    #1;
    chk("step2_fetches", 64'(fa_addr.size()), 64'(2));
    chk("step2_pc", 64'(pc_out), 64'(2));
    chk("step2_mem61", 64'(mem_rd(61)), 64'(12'h5A5));
    #1;
    step_mode = 1'b0;
    wait_halt(100);

    // Asynchronous reset in the middle of a MEMREAD wait.
    reset_assert();
    wait_n = 5;
    step_mode = 1'b0;
    ram[0] = 12'h13F;
    ram[1] = 12'h23D;
    ram[2] = 12'h700;
    ram[63] = 12'h123;
    release_run();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (state_out == 3'd3 && mem_req) break;
    end
    chk("reached_memread", 64'(state_out), 64'(3));
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("mid_rst_req_drop", 64'(mem_req), 64'(0));
    chk("mid_rst_state", 64'(state_out), 64'(0));
    chk("mid_rst_pc", 64'(pc_out), 64'(0));
    @(negedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_pc", 64'(pc_out), 64'(0));
    chk("post_rst_state", 64'(state_out), 64'(0));
    wait_halt(300);
    chk("post_rst_mem61", 64'(mem_rd(61)), 64'(12'h123));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zephyr_core_p.md
Name: zephyr_core_p

Overview:
- Parametrised multi-cycle successor to the zephyr CPU core: same FETCH/DECODE/EXECUTE/MEMREAD/MEMWRITE/REGWRITE sequencing, generalised data width, address width and register count.
- Adds a variable-latency req/ack memory port, arithmetic, branches, HALT, and a single-step debug mode.
- Sits between the system RAM (or a RAM wait-state wrapper) and the debug/testbench harness.

Parameters:
- DATA_W, 12, data and memory word width; must be >= IW.
- ADDR_W, 6, memory address width; PC width.
- RSEL_W, 2, register select width; register count is 2**RSEL_W.
- Derived: IW = 3+RSEL_W+ADDR_W. Instruction = memory word bits [IW-1:0]; upper bits are ignored.
- Instruction fields: op = [IW-1:IW-3], rs = next RSEL_W bits, addr = low ADDR_W bits.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- MEM_REQ  out  1  memory request, held until acknowledged.
- MEM_WE  out  1  1 = write, 0 = read; valid while MEM_REQ is high.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_WDATA  out  DATA_W  write data.
- MEM_RDATA  in  DATA_W  read data; valid in the MEM_ACK cycle.
- MEM_ACK  in  1  transfer completes on a rising edge where MEM_REQ && MEM_ACK.
- STEP_MODE  in  1  1 = execute one instruction per STEP pulse.
- STEP  in  1  single-step trigger; level sampled in FETCH.
- HALTED  out  1  core is in HALT.
- PC_OUT  out  ADDR_W  current PC.
- STATE_OUT  out  3  FETCH=0, DECODE=1, EXECUTE=2, MEMREAD=3, MEMWRITE=4, REGWRITE=5, HALT=6.

Behaviour:
- Reset (asynchronous, any state, including mid-transaction): state=FETCH, PC=0, IR=0, MDR=0, all registers 0; MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, HALTED=0. An abandoned request is simply dropped.
- Output timing: MEM_REQ/MEM_WE/MEM_ADDR/MEM_WDATA are decoded from registered state only, with no combinational path from MEM_ACK or STEP.
- FETCH:
  - MEM_REQ=1, MEM_WE=0, MEM_ADDR=PC.
  - Gated off (MEM_REQ=0) when STEP_MODE=1 and STEP=0.
  - On ack: IR <= MEM_RDATA, PC <= PC+1 mod 2**ADDR_W, go to DECODE.
  - Without ack: stay in FETCH, outputs held stable.
- DECODE: one cycle, go to EXECUTE.
- EXECUTE (one cycle):
  - op 000 NOP -> FETCH.
  - op 001 LOAD -> MEMREAD.
  - op 010 STR -> MEMWRITE.
  - op 011 ADD -> MEMREAD.
  - op 100 JMP: PC <= addr -> FETCH.
  - op 101 JZ: if R[rs]==0 then PC <= addr -> FETCH.
  - op 110: reserved, treated as NOP.
  - op 111 HALT -> HALT.
- MEMREAD: MEM_REQ=1, MEM_WE=0, MEM_ADDR=addr. On ack: MDR <= MEM_RDATA, go to REGWRITE.
- MEMWRITE: MEM_REQ=1, MEM_WE=1, MEM_ADDR=addr, MEM_WDATA=R[rs]. On ack go to FETCH.
- REGWRITE:
  - LOAD: R[rs] <= MDR.
  - ADD: R[rs] <= (R[rs]+MDR) mod 2**DATA_W; carry is discarded.
  - Then go to FETCH.
- HALT: HALTED=1, MEM_REQ=0. Only reset leaves HALT; STEP is ignored.
- Cycle counts with zero-wait ack (ack in the first request cycle):
  - NOP, JMP, JZ: 3 cycles.
  - STR: 4 cycles.
  - LOAD, ADD: 5 cycles.
  - Each wait cycle (request without ack) adds one cycle.
- PC wraps from 2**ADDR_W-1 to 0 on fetch. A JMP to the current instruction address loops indefinitely.
- Single-step:
  - STEP is sampled only in FETCH.
  - STEP=1 there starts exactly one instruction. A STEP held high runs continuously; the debug harness drives one-cycle pulses.
  - STEP_MODE may change at any time and takes effect at the next FETCH.
- Illegal parameterisation (DATA_W < IW) is rejected at elaboration.

Test Plan:
- Reset then zero-wait memory. Program: LOAD R0,63 / STR R0,61 / LOAD R1,62 / STR R1,60; mem[63]=0xFFF, mem[62]=0xFFA -> mem[61]=0xFFF, mem[60]=0xFFA; R0=0xFFF, R1=0xFFA; STATE_OUT sequence 0,1,2,3,5 for each LOAD; total 18 cycles.
- ADD wrap: R2 loaded with 0xFFF, then ADD R2 from an address holding 0x002 -> R2=0x001.
- Branching: JZ R3 to 10 with R3=0 -> PC_OUT=10; with R3=5 -> PC_OUT advances by 1. JMP 0 from address 63 -> PC_OUT=0.
- Wait states: MEM_ACK delayed 3 cycles on every request -> LOAD takes 11 cycles; MEM_ADDR/MEM_WE/MEM_WDATA stable throughout each wait.
- Single-step: STEP_MODE=1, STEP low 20 cycles -> MEM_REQ=0, STATE_OUT=0; one STEP pulse -> exactly one instruction, then back to FETCH.
- HALT then reset: HALT instruction -> HALTED=1 and MEM_REQ=0 for 50 cycles. Assert RESET_N=0 mid-MEMREAD -> MEM_REQ drops immediately; PC_OUT=0 and STATE_OUT=0 after release.
